// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizing for the memory request arbiter.
// Request bundle, requester ID and arbiter FSM state live here.
package mem_arb_pkg;

    localparam int ARB_NO_REQ    = 4;
    localparam int ARB_ADDR_W    = 32;
    localparam int ARB_DATA_W    = 32;
    localparam int ARB_MAX_OUTST = 4;
    localparam int ARB_ID_W      = $clog2(ARB_NO_REQ);

    typedef logic [ARB_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  we;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic {
        ARB,
        HOLD
    } arb_state_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: requester-side and memory-side signals of the arbiter.
// The arbiter uses the master view; the surrounding system uses slave.
interface mem_req_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NoReq = ARB_NO_REQ,
    parameter int AddrW = ARB_ADDR_W,
    parameter int DataW = ARB_DATA_W
);

    logic [NoReq-1:0]       req_valid_i;
    logic [NoReq*AddrW-1:0] req_addr_i;
    logic [NoReq-1:0]       req_we_i;
    logic [NoReq*DataW-1:0] req_wdata_i;
    logic [NoReq-1:0]       req_ready_o;

    logic                   mem_valid_o;
    logic [AddrW-1:0]       mem_addr_o;
    logic                   mem_we_o;
    logic [DataW-1:0]       mem_wdata_o;
    logic                   mem_ready_i;
    logic                   mem_rvalid_i;
    logic [DataW-1:0]       mem_rdata_i;

    logic [NoReq-1:0]       resp_valid_o;
    logic [DataW-1:0]       resp_data_o;

    modport master (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i,
        output req_ready_o,
        output mem_valid_o, mem_addr_o, mem_we_o, mem_wdata_o,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output resp_valid_o, resp_data_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i,
        input  req_ready_o,
        input  mem_valid_o, mem_addr_o, mem_we_o, mem_wdata_o,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  resp_valid_o, resp_data_o
    );

endinterface

// File: rtl/mem_arb_tag_fifo.sv
// mem_arb_tag_fifo: in-order record of which requester owns each
// outstanding memory request; pop frees a slot before push checks full.
module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int Depth = ARB_MAX_OUTST
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  req_id_t din,
    output req_id_t head,
    output logic    full,
    output logic    empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

    req_id_t         slots_q [Depth];
    logic [PtrW-1:0] wr_q;
    logic [PtrW-1:0] rd_q;
    logic [PtrW:0]   cnt_q;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FullCnt);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = slots_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                slots_q[wr_q] <= din;
                wr_q          <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + {{PtrW{1'b0}}, do_push}
                           - {{PtrW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin sharing of one in-order memory port.
// Define MEM_ARB_PRIO0_EN to give requester 0 strict priority.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NoReq    = ARB_NO_REQ,
    parameter int AddrW    = ARB_ADDR_W,
    parameter int DataW    = ARB_DATA_W,
    parameter int MaxOutst = ARB_MAX_OUTST
) (
    input logic               clk,
    input logic               rst,
    mem_req_arbiter_if.master bus
);

`ifdef MEM_ARB_PRIO0_EN
    localparam bit Prio0 = 1'b1;
`else
    localparam bit Prio0 = 1'b0;
`endif

    arb_state_t state_q;
    arb_state_t state_d;
    req_id_t    rr_q;
    req_id_t    grant_q;
    req_id_t    sel_id;
    req_id_t    cand;
    req_id_t    fifo_head;
    mem_req_t   req_q;
    logic       sel_valid;
    logic       load;
    logic       hs;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;

    // First valid requester at or after the rr pointer, wrapping.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        cand      = '0;
        if (Prio0 && bus.req_valid_i[0]) begin
            sel_valid = 1'b1;
        end
        for (int k = 0; k < NoReq; k++) begin
            cand = req_id_t'((int'(rr_q) + k) % NoReq);
            if (!sel_valid && bus.req_valid_i[cand] &&
                !(Prio0 && cand == '0)) begin
                sel_valid = 1'b1;
                sel_id    = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        hs      = 1'b0;
        unique case (state_q)
            ARB: begin
                if (sel_valid && !fifo_full) begin
                    state_d = HOLD;
                    load    = 1'b1;
                end
            end
            HOLD: begin
                if (bus.mem_ready_i) begin
                    state_d = ARB;
                    hs      = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            rr_q    <= '0;
            grant_q <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                grant_q     <= sel_id;
                req_q.addr  <= bus.req_addr_i[int'(sel_id)*AddrW +: AddrW];
                req_q.we    <= bus.req_we_i[sel_id];
                req_q.wdata <= bus.req_wdata_i[int'(sel_id)*DataW +: DataW];
            end
            // Requester 0 grants leave the pointer alone under strict priority.
            if (hs && !(Prio0 && grant_q == '0)) begin
                rr_q <= (int'(grant_q) == NoReq - 1) ? '0 : grant_q + 1'b1;
            end
        end
    end

    assign bus.mem_valid_o = (state_q == HOLD);
    assign bus.mem_addr_o  = req_q.addr;
    assign bus.mem_we_o    = req_q.we;
    assign bus.mem_wdata_o = req_q.wdata;

    always_comb begin
        bus.req_ready_o = '0;
        if (hs) begin
            bus.req_ready_o[grant_q] = 1'b1;
        end
    end

    // Responses with no outstanding tag are dropped.
    assign pop = bus.mem_rvalid_i & ~fifo_empty;

    always_comb begin
        bus.resp_valid_o = '0;
        bus.resp_data_o  = '0;
        if (pop) begin
            bus.resp_valid_o[fifo_head] = 1'b1;
            bus.resp_data_o             = bus.mem_rdata_i;
        end
    end

    mem_arb_tag_fifo #(
        .Depth (MaxOutst)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hs),
        .pop   (pop),
        .din   (grant_q),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed scoreboard bench for mem_req_arbiter.
// Grants and responses are checked by monitors against queued expectations.
module tb_mem_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } exp_grant_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_resp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    exp_grant_t exp_g[$];
    exp_resp_t  exp_r[$];

    mem_req_arbiter_if #(.NoReq(NR), .AddrW(AW), .DataW(DW)) bus ();

    mem_req_arbiter #(
        .NoReq    (NR),
        .AddrW    (AW),
        .DataW    (DW),
        .MaxOutst (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [31:0] wdata_of(input int i);
        return 32'h5000 + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic we, input logic [31:0] d);
        bus.req_addr_i[i*AW +: AW]  = a;
        bus.req_we_i[i]             = we;
        bus.req_wdata_i[i*DW +: DW] = d;
    endtask

    task automatic push_grant(input int id);
        exp_grant_t g;
        g.id    = id;
        g.addr  = bus.req_addr_i[id*AW +: AW];
        g.we    = bus.req_we_i[id];
        g.wdata = bus.req_wdata_i[id*DW +: DW];
        exp_g.push_back(g);
    endtask

    task automatic respond(input int id, input logic [31:0] d);
        exp_resp_t r;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = d;
        r.id   = id;
        r.data = d;
        exp_r.push_back(r);
    endtask

    task automatic reset_dut();
        rst              = 1'b1;
        bus.req_valid_i  = '0;
        bus.mem_ready_i  = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic stream(input int ord[$], input logic [NR-1:0] mask);
        int n;
        n = ord.size();
        foreach (ord[j]) push_grant(ord[j]);
        bus.mem_ready_i = 1'b1;
        bus.req_valid_i = mask;
        for (int c = 1; c <= 2 * n; c++) begin
            tick();
            if (c == 2 * n) bus.req_valid_i = '0;
            if (c % 2 == 0) respond(ord[c/2-1], 32'hA000_0000 + 32'(c));
            else bus.mem_rvalid_i = 1'b0;
        end
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_ready_i  = 1'b0;
    endtask

    // Grant monitor
    always @(negedge clk) begin
        if (!rst && bus.req_ready_o != '0) begin
            if (exp_g.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got 0x%0h, expected none",
                         bus.req_ready_o);
            end else begin
                exp_grant_t g;
                g = exp_g.pop_front();
                check("grant_onehot", 64'(bus.req_ready_o), 64'(1) << g.id);
                check("grant_addr", 64'(bus.mem_addr_o), 64'(g.addr));
                check("grant_we", 64'(bus.mem_we_o), 64'(g.we));
                check("grant_wdata", 64'(bus.mem_wdata_o), 64'(g.wdata));
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (!rst && bus.resp_valid_o != '0) begin
            if (exp_r.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got 0x%0h, expected none",
                         bus.resp_valid_o);
            end else begin
                exp_resp_t r;
                r = exp_r.pop_front();
                check("resp_onehot", 64'(bus.resp_valid_o), 64'(1) << r.id);
                check("resp_data", 64'(bus.resp_data_o), 64'(r.data));
            end
        end
    end

    initial begin
        int ord[$];
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.req_valid_i  = '0;
        bus.mem_ready_i  = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        for (int i = 0; i < NR; i++) set_req(i, addr_of(i), i[0], wdata_of(i));

        // Reset state and single read
        reset_dut();
        @(negedge clk);
        check("rst_mem_valid", 64'(bus.mem_valid_o), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        check("rst_resp_data", 64'(bus.resp_data_o), 64'd0);
        tick();
        set_req(0, 32'h10, 1'b0, 32'h0);
        bus.req_valid_i = 4'b0001;
        bus.mem_ready_i = 1'b1;
        push_grant(0);
        @(negedge clk);
        check("arb_latency", 64'(bus.mem_valid_o), 64'd0);
        tick();
        @(negedge clk);
        check("single_valid", 64'(bus.mem_valid_o), 64'd1);
        check("single_ready", 64'(bus.req_ready_o), 64'h1);
        tick();
        bus.req_valid_i = '0;
        respond(0, 32'hDEAD_BEEF);
        tick();
        bus.mem_rvalid_i = 1'b0;
        set_req(0, addr_of(0), 1'b0, wdata_of(0));

        // All four requesters back to back
        reset_dut();
        ord = '{0, 1, 2, 3, 0};
        stream(ord, 4'b1111);

        // Memory stalls for five cycles
        reset_dut();
        bus.req_valid_i = 4'b0100;
        push_grant(2);
        for (int c = 1; c <= 5; c++) begin
            tick();
            @(negedge clk);
            check("stall_valid", 64'(bus.mem_valid_o), 64'd1);
            check("stall_addr", 64'(bus.mem_addr_o), 64'(addr_of(2)));
            check("stall_we", 64'(bus.mem_we_o), 64'd0);
            check("stall_wdata", 64'(bus.mem_wdata_o), 64'(wdata_of(2)));
            check("stall_ready", 64'(bus.req_ready_o), 64'd0);
        end
        tick();
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        check("stall_accept", 64'(bus.req_ready_o), 64'h4);
        tick();
        bus.req_valid_i = '0;
        bus.mem_ready_i = 1'b0;
        respond(2, 32'h77);
        tick();
        bus.mem_rvalid_i = 1'b0;

        // Tag FIFO full stalls the fifth request
        reset_dut();
        bus.req_valid_i = 4'b1010;
        bus.mem_ready_i = 1'b1;
        push_grant(1);
        push_grant(3);
        push_grant(1);
        push_grant(3);
        push_grant(1);
        for (int c = 1; c <= 7; c++) tick();
        for (int c = 8; c <= 9; c++) begin
            tick();
            @(negedge clk);
            check("full_stall", 64'(bus.mem_valid_o), 64'd0);
        end
        tick();
        respond(1, 32'hB1);
        @(negedge clk);
        check("full_stall_pop", 64'(bus.mem_valid_o), 64'd0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        tick();
        @(negedge clk);
        check("full_resume", 64'(bus.mem_valid_o), 64'd1);
        tick();
        bus.req_valid_i = '0;
        for (int k = 0; k < 4; k++) begin
            respond((k % 2 == 0) ? 3 : 1, 32'hB2 + 32'(k));
            tick();
        end
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hEE;
        @(negedge clk);
        check("drop_empty", 64'(bus.resp_valid_o), 64'd0);
        tick();
        bus.mem_rvalid_i = 1'b0;

        // Requesters 0 and 2 contend
        reset_dut();
`ifdef MEM_ARB_PRIO0_EN
        ord = '{0, 0, 0, 0};
`else
        ord = '{0, 2, 0, 2};
`endif
        stream(ord, 4'b0101);

        // Reset with three outstanding requests
        reset_dut();
        bus.req_valid_i = 4'b0111;
        bus.mem_ready_i = 1'b1;
        push_grant(0);
        push_grant(1);
        push_grant(2);
        for (int c = 1; c <= 5; c++) tick();
        tick();
        bus.req_valid_i = 4'b1000;
        bus.mem_ready_i = 1'b0;
        tick();
        rst = 1'b1;
        bus.req_valid_i = '0;
        @(negedge clk);
        check("pre_rst_valid", 64'(bus.mem_valid_o), 64'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_mem_valid", 64'(bus.mem_valid_o), 64'd0);
        check("mid_rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        check("mid_rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        check("mid_rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        check("mid_rst_resp_data", 64'(bus.resp_data_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 32'hCC + 32'(k);
            @(negedge clk);
            check("post_rst_drop", 64'(bus.resp_valid_o), 64'd0);
            check("post_rst_data", 64'(bus.resp_data_o), 64'd0);
        end
        tick();
        bus.mem_rvalid_i = 1'b0;
        tick();

        check("grants_left", 64'(exp_g.size()), 64'd0);
        check("resps_left", 64'(exp_r.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
